// File: rtl/deal_pkg.sv
// Shared types and helpers for the baccarat deal sequencer.
// Holds the sequencer state encoding and the card-code to point-value mapping.
package deal_pkg;

  // Sequencer states, in deal order; S_DONE is terminal until reset.
  typedef enum logic [3:0] {
    S_P1     = 4'd0,
    S_D1     = 4'd1,
    S_P2     = 4'd2,
    S_D2     = 4'd3,
    S_CHECK  = 4'd4,
    S_P3     = 4'd5,
    S_BANKER = 4'd6,
    S_D3     = 4'd7,
    S_DONE   = 4'd8
  } state_e;

  // A hand total at or above this value is a natural and ends the deal.
  localparam logic [3:0] NATURAL_MIN = 4'd8;

  // Highest total on which a hand still takes a third card.
  localparam logic [3:0] DRAW_MAX = 4'd5;

  // Point value of a card code: ace..nine count face value,
  // ten/jack/queen/king and "no card" (code 0) count zero.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    logic [3:0] value;
    if ((code >= 4'd1) && (code <= 4'd9)) begin
      value = code;
    end else begin
      value = 4'd0;
    end
    return value;
  endfunction

endpackage

// File: rtl/deal_sequencer_if.sv
// Signal bundle between the deal sequencer and its datapath/driver.
// The master side supplies step and the hand scores; the slave side
// (the sequencer) returns the capture strobes and the result indicators.
interface deal_sequencer_if;

  logic       step;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;

  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;

  logic       player_win_light;
  logic       dealer_win_light;
  logic       hand_done;

  modport master (
    output step, pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, hand_done
  );

  modport slave (
    input  step, pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, hand_done
  );

endinterface

// File: rtl/banker_rule.sv
// Banker third-card decision: purely combinational, given the banker's
// two-card total and the player's third card code. Kept as its own
// module so the datapath tests can reuse it unchanged.
module banker_rule
  import deal_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] pvalue;

  // Decide whether the banker takes a third card.
  always_comb begin
    pvalue = card_value(pcard3);
    draw   = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (pvalue != 4'd8);
      4'd4:             draw = (pvalue >= 4'd2) && (pvalue <= 4'd7);
      4'd5:             draw = (pvalue >= 4'd4) && (pvalue <= 4'd7);
      4'd6:             draw = (pvalue >= 4'd6) && (pvalue <= 4'd7);
      // 7 always stands; totals above 9 never draw.
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/deal_sequencer.sv
// Baccarat deal sequencer. Walks the fixed deal order one card per step,
// applies the natural / player / banker third-card rules, then parks in
// S_DONE showing the result. The state register is the only storage;
// every output is decoded from the current state and step.
module deal_sequencer
  import deal_pkg::*;
(
  input  logic             slow_clock,
  input  logic             reset,
  deal_sequencer_if.slave  bus
);

  state_e state_q;
  state_e state_d;
  logic   banker_draw;
  logic   natural;

  banker_rule u_banker_rule (
    .dscore (bus.dscore),
    .pcard3 (bus.pcard3),
    .draw   (banker_draw)
  );

  // State register; reset abandons any hand in progress.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      state_q <= S_P1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection; nothing moves unless step is high.
  always_comb begin
    state_d = state_q;
    natural = (bus.pscore >= NATURAL_MIN) || (bus.dscore >= NATURAL_MIN);
    if (bus.step) begin
      case (state_q)
        S_P1:    state_d = S_D1;
        S_D1:    state_d = S_P2;
        S_P2:    state_d = S_D2;
        S_D2:    state_d = S_CHECK;
        S_CHECK: begin
          if (natural) begin
            state_d = S_DONE;
          end else if (bus.pscore <= DRAW_MAX) begin
            state_d = S_P3;
          end else if (bus.dscore <= DRAW_MAX) begin
            state_d = S_D3;
          end else begin
            state_d = S_DONE;
          end
        end
        S_P3:     state_d = S_BANKER;
        S_BANKER: state_d = banker_draw ? S_D3 : S_DONE;
        S_D3:     state_d = S_DONE;
        S_DONE:   state_d = S_DONE;
        default:  state_d = S_P1;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output decode: one capture strobe per load state, result lights in
  // S_DONE; everything is forced low while reset is asserted.
  always_comb begin
    bus.load_pcard1      = 1'b0;
    bus.load_pcard2      = 1'b0;
    bus.load_pcard3      = 1'b0;
    bus.load_dcard1      = 1'b0;
    bus.load_dcard2      = 1'b0;
    bus.load_dcard3      = 1'b0;
    bus.player_win_light = 1'b0;
    bus.dealer_win_light = 1'b0;
    bus.hand_done        = 1'b0;
    if (!reset) begin
      case (state_q)
        S_P1:   bus.load_pcard1 = bus.step;
        S_D1:   bus.load_dcard1 = bus.step;
        S_P2:   bus.load_pcard2 = bus.step;
        S_D2:   bus.load_dcard2 = bus.step;
        S_P3:   bus.load_pcard3 = bus.step;
        S_D3:   bus.load_dcard3 = bus.step;
        S_DONE: begin
          bus.hand_done        = 1'b1;
          // A tie lights both indicators.
          bus.player_win_light = (bus.pscore >= bus.dscore);
          bus.dealer_win_light = (bus.pscore <= bus.dscore);
        end
        default: begin
          bus.hand_done = 1'b0;
        end
      endcase
    end else begin
      bus.hand_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_deal_sequencer.sv
// Scoreboard bench for deal_sequencer: each hand's expected strobe order
// and result lights are queued by the stimulus side; a negedge monitor
// pops and compares whenever the sequencer shows a strobe or finishes.
module tb_deal_sequencer;

  logic slow_clock = 1'b0;
  logic reset;

  deal_sequencer_if bus ();

  deal_sequencer dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 slow_clock = ~slow_clock;

  int total = 0;
  int bad   = 0;

  // Expected strobe ids: 0=pcard1 1=dcard1 2=pcard2 3=dcard2 4=pcard3 5=dcard3
  int       exp_q[$];
  bit [1:0] exp_lights_q[$];   // {player, dealer}
  bit       lights_seen = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [8:0] all_outputs();
    return {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2, bus.load_dcard2,
            bus.load_pcard3, bus.load_dcard3, bus.player_win_light,
            bus.dealer_win_light, bus.hand_done};
  endfunction

  // ---------------- reference model (baccarat rules) ----------------
  function automatic int point_value(input int code);
    return ((code >= 1) && (code <= 9)) ? code : 0;
  endfunction

  function automatic bit banker_takes(input int d, input int v);
    if (d <= 2) return 1'b1;
    if (d == 3) return (v != 8);
    // totals 4,5,6 draw when v lies between 2*(d-3) and 7
    if (d <= 6) return (v >= 2 * (d - 3)) && (v <= 7);
    return 1'b0;
  endfunction

  task automatic plan_hand(input int p, input int d, input int c);
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    if (!((p >= 8) || (d >= 8))) begin
      if (p <= 5) begin
        exp_q.push_back(4);
        if (banker_takes(d, point_value(c))) exp_q.push_back(5);
      end else if (d <= 5) begin
        exp_q.push_back(5);
      end
    end
    if (p > d)      exp_lights_q.push_back(2'b10);
    else if (p < d) exp_lights_q.push_back(2'b01);
    else            exp_lights_q.push_back(2'b11);
  endtask

  // ---------------- monitor ----------------
  always @(negedge slow_clock) begin
    logic [5:0] s;
    int idx;
    s = {bus.load_dcard3, bus.load_pcard3, bus.load_dcard2,
         bus.load_pcard2, bus.load_dcard1, bus.load_pcard1};
    idx = -1;
    if (!reset) begin
      if (!bus.step) begin
        check("quiet_when_step_low", int'(s), 0);
      end else if (s != 6'd0) begin
        check("one_strobe", $countones(s), 1);
        for (int i = 0; i < 6; i++) if (s[i]) idx = i;
        if (idx == 0) lights_seen = 1'b0;
        if (exp_q.size() == 0) check("unexpected_strobe", idx, -1);
        else                   check("strobe_order", idx, exp_q.pop_front());
      end
      if (bus.hand_done) begin
        if (!lights_seen) begin
          lights_seen = 1'b1;
          check("done_strobes_consumed", exp_q.size(), 0);
          if (exp_lights_q.size() == 0)
            check("unexpected_done", int'({bus.player_win_light, bus.dealer_win_light}), -1);
          else
            check("win_lights", int'({bus.player_win_light, bus.dealer_win_light}),
                  int'(exp_lights_q.pop_front()));
        end
      end else begin
        check("lights_off", int'({bus.player_win_light, bus.dealer_win_light}), 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    bus.step = 1'b0;
    @(posedge slow_clock);
    #2 reset = 1'b1;
    #1 check("reset_outputs", int'(all_outputs()), 0);
    bus.step = 1'b1;
    #1 check("reset_outputs_step_high", int'(all_outputs()), 0);
    bus.step = 1'b0;
    @(negedge slow_clock);
    #1 reset = 1'b0;
  endtask

  task automatic run_hand(input int p, input int d, input int c, input bit rand_step);
    int cyc;
    int done_cyc;
    cyc = 0;
    done_cyc = 0;
    bus.pscore = p[3:0];
    bus.dscore = d[3:0];
    bus.pcard3 = c[3:0];
    plan_hand(p, d, c);
    while ((done_cyc < 3) && (cyc < 200)) begin
      @(posedge slow_clock);
      #1 bus.step = rand_step ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge slow_clock);
      #1 if (bus.hand_done) done_cyc++;
      cyc++;
    end
    check("hand_finished_in_budget", int'(done_cyc >= 3), 1);
    check("no_missing_strobes", exp_q.size(), 0);
    check("lights_consumed", exp_lights_q.size(), 0);
    exp_q.delete();
    exp_lights_q.delete();
    bus.step = 1'b0;
  endtask

  initial begin
    bus.step   = 1'b0;
    bus.pscore = 4'd0;
    bus.dscore = 4'd0;
    bus.pcard3 = 4'd0;
    reset      = 1'b1;
    #3 bus.step = 1'b1;
    #1 check("power_on_reset_outputs", int'(all_outputs()), 0);
    repeat (2) @(posedge slow_clock);
    #1 check("reset_held_across_edges", int'(all_outputs()), 0);
    bus.step = 1'b0;
    @(negedge slow_clock);
    #1 reset = 1'b0;

    // Directed hands: natural, player+banker draw, banker stand on face card,
    // tie with no draws, banker-only draw, then random-step variants.
    run_hand(8, 3, 0, 1'b0);
    do_reset(); run_hand(4, 5, 6, 1'b0);
    do_reset(); run_hand(4, 5, 12, 1'b0);
    do_reset(); run_hand(7, 7, 0, 1'b0);
    do_reset(); run_hand(7, 5, 0, 1'b0);
    do_reset(); run_hand(3, 3, 8, 1'b1);
    do_reset(); run_hand(0, 0, 0, 1'b1);
    do_reset(); run_hand(5, 6, 7, 1'b1);

    // Random hands with random step gaps; occasionally out-of-range totals.
    for (int h = 0; h < 60; h++) begin
      int p;
      int d;
      p = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      do_reset();
      run_hand(p, d, $urandom_range(0, 13), 1'b1);
    end

    // Abort mid-hand in S_P3 with an asynchronous reset pulse.
    do_reset();
    bus.pscore = 4'd4;
    bus.dscore = 4'd5;
    bus.pcard3 = 4'd6;
    plan_hand(4, 5, 6);
    repeat (6) begin
      @(posedge slow_clock);
      #1 bus.step = 1'b1;
    end
    @(negedge slow_clock);
    #1 check("abort_reached_p3", int'(bus.load_pcard3), 1);
    #1 reset = 1'b1;
    #1 check("abort_outputs_zero", int'(all_outputs()), 0);
    exp_q.delete();
    exp_lights_q.delete();
    bus.step = 1'b0;
    @(negedge slow_clock);
    #1 reset = 1'b0;
    run_hand(4, 5, 6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deal_sequencer.md
DEAL_SEQUENCER -- requirements
Module: deal_sequencer

Interface
REQ-001 The block SHALL have port slow_clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port step, input, 1 bit: enables advance; while low, the FSM holds its state and all load outputs are 0.
REQ-004 The block SHALL have ports pscore and dscore, input, 4 bits each: current player and dealer hand totals, 0-9, from the datapath score logic.
REQ-005 The block SHALL have port pcard3, input, 4 bits: player third-card code, 0 = none, 1-13 = A..K.
REQ-006 The block SHALL have ports load_pcard1, load_pcard2 and load_pcard3, output, 1 bit each: capture strobes for the player card registers.
REQ-007 The block SHALL have ports load_dcard1, load_dcard2 and load_dcard3, output, 1 bit each: capture strobes for the dealer card registers.
REQ-008 The block SHALL have ports player_win_light and dealer_win_light, output, 1 bit each: result indicators.
REQ-009 The block SHALL have port hand_done, output, 1 bit: high while in S_DONE.

Function
REQ-010 The FSM SHALL have states S_P1, S_D1, S_P2, S_D2, S_CHECK, S_P3, S_BANKER, S_D3 and S_DONE; the reset state is S_P1.
REQ-011 Each transition SHALL occur only on a rising edge with step=1; with step=0 the state is held.
REQ-012 In S_P1, S_D1, S_P2, S_D2, S_P3 and S_D3 the matching load output SHALL equal step (combinational); all other loads SHALL be 0, so at most one load is high in any cycle.
REQ-013 The deal order SHALL be S_P1->S_D1->S_P2->S_D2->S_CHECK: one card per step edge.
REQ-014 S_CHECK SHALL go to S_DONE if pscore>=8 or dscore>=8 (natural); else to S_P3 if pscore<=5; else to S_D3 if dscore<=5; else to S_DONE.
REQ-015 S_P3 SHALL go to S_BANKER; S_BANKER SHALL evaluate the banker rule using dscore and v = value(pcard3).
REQ-016 The card value mapping SHALL be: code 1-9 -> the code itself; code 0 or 10-13 -> 0.
REQ-017 The banker SHALL draw (go to S_D3, else to S_DONE) when any of these holds:
- dscore 0-2
- dscore 3 and v!=8
- dscore 4 and v in 2-7
- dscore 5 and v in 4-7
- dscore 6 and v in 6-7
- dscore 7 never draws.
REQ-018 S_D3 SHALL go to S_DONE.
REQ-019 S_DONE SHALL be absorbing; it is left only by reset.
REQ-020 In S_DONE: pscore>dscore gives player_win_light=1 only; pscore<dscore gives dealer_win_light=1 only; a tie gives both = 1. Both lights SHALL be 0 in all other states.
REQ-021 Score comparisons SHALL be unsigned 4-bit; inputs above 9 are out of contract, but the FSM SHALL still follow REQ-014 and REQ-017 literally.

Reset
REQ-022 While reset=1: state = S_P1, all loads = 0, both lights = 0, hand_done = 0, regardless of step or the clock.
REQ-023 Reset asserted mid-hand (any state) SHALL abandon the hand; after deassertion the first step edge SHALL produce load_pcard1.
REQ-024 The state register SHALL be the only storage; all outputs are decoded from the state plus step.

Structure
REQ-025 Package deal_pkg SHALL hold the state enum and the card-value function.
REQ-026 The banker decision SHALL be one combinational sub-module, banker_rule (inputs dscore and pcard3; output draw), reused unchanged by the datapath tests.

Verification
REQ-027 Reset, then step held high: strobes SHALL fire in the order load_pcard1, load_dcard1, load_pcard2, load_dcard2 on four consecutive cycles.
REQ-028 At S_CHECK with pscore=8, dscore=3 -> S_DONE next edge with no third-card loads, player_win_light=1 and dealer_win_light=0.
REQ-029 With pscore=4, dscore=5 and pcard3=6 -> load_pcard3 then load_dcard3, then S_DONE; with pcard3=12 instead, no load_dcard3 occurs.
REQ-030 With pscore=7, dscore=7 at S_CHECK -> S_DONE with both lights = 1 (tie); with dscore=5 instead, load_dcard3 occurs first.
REQ-031 With step toggled 1-0-0-1 -> the state is held during the zero cycles and no strobe fires while step=0.
REQ-032 Reset pulsed asynchronously during S_P3 -> outputs are 0 immediately; the next step edge fires load_pcard1.
